// File: rtl/eq_pkg.sv
// Shared definitions for the equaliser gain path: default sizes, the
// smoother FSM encoding and the packed per-band bus slicing convention.
package eq_pkg;

  localparam int unsigned EQ_NUM_FILTERS = 10;
  localparam int unsigned EQ_GAIN_BITS   = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } eq_state_e;

  // Lowest bit of band 'band' on a packed gain bus; band i lives at
  // [i*gain_bits +: gain_bits], the same layout the EQ expects.
  function automatic int unsigned band_lsb(input int unsigned band,
                                           input int unsigned gain_bits);
    return band * gain_bits;
  endfunction

endpackage

// File: rtl/eq_gain_step.sv
// One band of the smoother: moves the gain one LSB toward its target when
// strobed, never overshooting, and flags when the post-step gain is on target.
module eq_gain_step
  import eq_pkg::*;
#(
  parameter int unsigned GAIN_BITS = EQ_GAIN_BITS
) (
  input  logic [GAIN_BITS-1:0] gain_i,
  input  logic [GAIN_BITS-1:0] target_i,
  input  logic                 step_i,
  output logic [GAIN_BITS-1:0] gain_next_o,
  output logic                 at_target_o
);

  // Step toward target by one LSB; equality means hold, so no wrap at 0 or max.
  always_comb begin
    gain_next_o = gain_i;
    if (step_i) begin
      if (gain_i < target_i) begin
        gain_next_o = gain_i + GAIN_BITS'(1);
      end else if (gain_i > target_i) begin
        gain_next_o = gain_i - GAIN_BITS'(1);
      end
    end
    at_target_o = (gain_next_o == target_i);
  end

endmodule

// File: rtl/eq_gain_smoother.sv
// Ramps the packed per-band EQ gain toward a loaded target one LSB per
// STEP_SAMPLES sample ticks, reporting completion with a one-cycle done pulse.
//
// Handshake: a target is taken on any rising clk edge where load_valid and
// load_ready are both high; gain_target is captured on that edge. load_valid
// while load_ready is low has no effect. The offering side may drop or change
// load_valid at will; nothing is held pending.
module eq_gain_smoother
  import eq_pkg::*;
#(
  parameter int unsigned NUMBER_OF_FILTERS = EQ_NUM_FILTERS,
  parameter int unsigned GAIN_BITS         = EQ_GAIN_BITS,
  parameter int unsigned STEP_SAMPLES      = 4,
  parameter int unsigned RESET_GAIN        = 1,
  parameter bit          ALLOW_RETARGET    = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   sample_tick,
  input  logic                                   load_valid,
  output logic                                   load_ready,
  input  logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0] gain_target,
  output logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0] gain,
  output logic                                   settled,
  output logic                                   done,
  output logic                                   state_dbg
);

  localparam int unsigned BUS_W = NUMBER_OF_FILTERS * GAIN_BITS;
  localparam int unsigned DIV_W = (STEP_SAMPLES > 1) ? $clog2(STEP_SAMPLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_SAMPLES - 1);
  localparam logic [BUS_W-1:0] RESET_VEC = {NUMBER_OF_FILTERS{GAIN_BITS'(RESET_GAIN)}};

  eq_state_e                     state_q, state_d;
  logic      [BUS_W-1:0]         gain_q, gain_d;
  logic      [BUS_W-1:0]         target_q, target_d;
  logic      [DIV_W-1:0]         div_q, div_d;
  logic                          done_q, done_d;
  logic      [BUS_W-1:0]         step_gain;
  logic      [NUMBER_OF_FILTERS-1:0] at_target;
  logic                          accept;
  logic                          step;

  assign load_ready = ALLOW_RETARGET ? !reset : (state_q == ST_IDLE);
  assign accept     = load_valid && load_ready;
  // A new target on the same edge as a step-eligible tick wins; no step then.
  assign step       = (state_q == ST_RAMP) && sample_tick && (div_q == DIV_LAST) && !accept;

  for (genvar g = 0; g < NUMBER_OF_FILTERS; g++) begin : g_band
    eq_gain_step #(
      .GAIN_BITS (GAIN_BITS)
    ) u_step (
      .gain_i      (gain_q[band_lsb(g, GAIN_BITS) +: GAIN_BITS]),
      .target_i    (target_q[band_lsb(g, GAIN_BITS) +: GAIN_BITS]),
      .step_i      (step),
      .gain_next_o (step_gain[band_lsb(g, GAIN_BITS) +: GAIN_BITS]),
      .at_target_o (at_target[g])
    );
  end

  // Next-state: accept/retarget first, otherwise pace the ramp on sample ticks.
  always_comb begin
    state_d  = state_q;
    gain_d   = gain_q;
    target_d = target_q;
    div_d    = div_q;
    done_d   = 1'b0;
    if (accept) begin
      target_d = gain_target;
      div_d    = '0;
      if (gain_target == gain_q) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RAMP;
      end
    end else if ((state_q == ST_RAMP) && sample_tick) begin
      if (div_q == DIV_LAST) begin
        gain_d = step_gain;
        div_d  = '0;
        if (&at_target) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // State registers; reset drops any ramp in progress without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      gain_q   <= RESET_VEC;
      target_q <= RESET_VEC;
      div_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gain_q   <= gain_d;
      target_q <= target_d;
      div_q    <= div_d;
      done_q   <= done_d;
    end
  end

  assign gain      = gain_q;
  assign done      = done_q;
  assign settled   = (state_q == ST_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_eq_gain_smoother.sv
// Directed bench for eq_gain_smoother: one instance with retargeting allowed
// and one without, driven by the same stimulus and compared every cycle
// against a per-band arithmetic model, plus hand-computed gain literals.
module tb_eq_gain_smoother;

  localparam int NB   = 10;
  localparam int GB   = 4;
  localparam int W    = NB * GB;
  localparam int STEP = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sample_tick = 1'b0;
  logic load_valid = 1'b0;
  logic [W-1:0] gain_target = '0;

  always #5 clk = ~clk;

  logic [W-1:0] gain_o     [2];
  logic         lr_o       [2];
  logic         settled_o  [2];
  logic         done_o     [2];
  logic         state_o    [2];

  eq_gain_smoother #(
    .NUMBER_OF_FILTERS (NB), .GAIN_BITS (GB), .STEP_SAMPLES (STEP),
    .RESET_GAIN (1), .ALLOW_RETARGET (1'b1)
  ) dut (
    .clk (clk), .reset (reset), .sample_tick (sample_tick),
    .load_valid (load_valid), .load_ready (lr_o[0]), .gain_target (gain_target),
    .gain (gain_o[0]), .settled (settled_o[0]), .done (done_o[0]), .state_dbg (state_o[0])
  );

  eq_gain_smoother #(
    .NUMBER_OF_FILTERS (NB), .GAIN_BITS (GB), .STEP_SAMPLES (STEP),
    .RESET_GAIN (1), .ALLOW_RETARGET (1'b0)
  ) dut_nr (
    .clk (clk), .reset (reset), .sample_tick (sample_tick),
    .load_valid (load_valid), .load_ready (lr_o[1]), .gain_target (gain_target),
    .gain (gain_o[1]), .settled (settled_o[1]), .done (done_o[1]), .state_dbg (state_o[1])
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int done_cnt [2] = '{0, 0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integer gains/targets per band, a "ramping" flag
  // and a sample counter, advanced once per clock edge from the spec rules.
  int m_gain [2][NB];
  int m_tgt  [2][NB];
  bit m_ramp [2];
  int m_div  [2];
  bit m_done [2];

  task automatic model_edge(input int k, input bit allow);
    bit rdy;
    bit all_eq;
    if (reset) begin
      for (int b = 0; b < NB; b++) begin
        m_gain[k][b] = 1;
        m_tgt[k][b]  = 1;
      end
      m_ramp[k] = 1'b0;
      m_div[k]  = 0;
      m_done[k] = 1'b0;
      return;
    end
    rdy = allow ? 1'b1 : !m_ramp[k];
    m_done[k] = 1'b0;
    if (load_valid && rdy) begin
      all_eq = 1'b1;
      for (int b = 0; b < NB; b++) begin
        m_tgt[k][b] = int'(gain_target[b*GB +: GB]);
        if (m_tgt[k][b] != m_gain[k][b]) all_eq = 1'b0;
      end
      m_div[k]  = 0;
      m_ramp[k] = !all_eq;
      m_done[k] = all_eq;
    end else if (m_ramp[k] && sample_tick) begin
      if (m_div[k] == STEP - 1) begin
        m_div[k] = 0;
        all_eq = 1'b1;
        for (int b = 0; b < NB; b++) begin
          if (m_gain[k][b] < m_tgt[k][b]) m_gain[k][b] = m_gain[k][b] + 1;
          else if (m_gain[k][b] > m_tgt[k][b]) m_gain[k][b] = m_gain[k][b] - 1;
          if (m_gain[k][b] != m_tgt[k][b]) all_eq = 1'b0;
        end
        if (all_eq) begin
          m_ramp[k] = 1'b0;
          m_done[k] = 1'b1;
        end
      end else begin
        m_div[k] = m_div[k] + 1;
      end
    end
  endtask

  // Compare process: model advances on the edge, outputs sampled 1 time unit later.
  always @(posedge clk) begin
    logic [W-1:0] exp_bus;
    model_edge(0, 1'b1);
    model_edge(1, 1'b0);
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_bus = '0;
      for (int b = 0; b < NB; b++) exp_bus[b*GB +: GB] = GB'(m_gain[k][b]);
      check($sformatf("gain[%0d]", k), 64'(gain_o[k]), 64'(exp_bus));
      check($sformatf("settled[%0d]", k), 64'(settled_o[k]), 64'(!m_ramp[k]));
      check($sformatf("state[%0d]", k), 64'(state_o[k]), 64'(m_ramp[k]));
      check($sformatf("done[%0d]", k), 64'(done_o[k]), 64'(m_done[k]));
      check($sformatf("load_ready[%0d]", k), 64'(lr_o[k]),
            64'((k == 0) ? !reset : !m_ramp[k]));
      if (done_o[k] === 1'b1) done_cnt[k]++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load(input logic [W-1:0] v);
    @(negedge clk);
    load_valid  = 1'b1;
    gain_target = v;
    @(negedge clk);
    load_valid  = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk) sample_tick = 1'b1;
      @(negedge clk) sample_tick = 1'b0;
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int c0, c1;

    // Reset held for two cycles: unity everywhere, idle, ready.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_gain", 64'(gain_o[0]), 64'h11_1111_1111);
    check("rst_settled", 64'(settled_o[0]), 64'd1);
    check("rst_ready", 64'(lr_o[0]), 64'd1);
    check("rst_done", 64'(done_o[0]), 64'd0);

    // Band0 1 -> 5: a step every 4 ticks, one done at tick 16.
    c0 = done_cnt[0];
    load(40'h11_1111_1115);
    ticks(4);
    check("up_t4", 64'(gain_o[0]), 64'h11_1111_1112);
    ticks(11);
    check("up_t15", 64'(gain_o[0]), 64'h11_1111_1114);
    check("up_t15_done", 64'(done_cnt[0] - c0), 64'd0);
    ticks(1);
    check("up_t16", 64'(gain_o[0]), 64'h11_1111_1115);
    check("up_t16_done", 64'(done_cnt[0] - c0), 64'd1);
    check("up_settled", 64'(settled_o[0]), 64'd1);

    // Band0 -> 0, band9 -> 15: independent bands, done waits for the slow one.
    do_reset();
    c0 = done_cnt[0];
    load(40'hF1_1111_1110);
    ticks(4);
    check("edge_t4", 64'(gain_o[0]), 64'h21_1111_1110);
    ticks(51);
    check("edge_t55", 64'(gain_o[0]), 64'hE1_1111_1110);
    check("edge_t55_settled", 64'(settled_o[0]), 64'd0);
    check("edge_t55_done", 64'(done_cnt[0] - c0), 64'd0);
    ticks(1);
    check("edge_t56", 64'(gain_o[0]), 64'hF1_1111_1110);
    check("edge_t56_done", 64'(done_cnt[0] - c0), 64'd1);

    // Retarget mid-ramp: accepted by dut, ignored by dut_nr.
    do_reset();
    c0 = done_cnt[0];
    c1 = done_cnt[1];
    load(40'h11_1111_1119);
    ticks(8);
    check("rt_t8", 64'(gain_o[0]), 64'h11_1111_1113);
    check("rt_nr_ready", 64'(lr_o[1]), 64'd0);
    load(40'h11_1111_1112);
    ticks(4);
    check("rt_new", 64'(gain_o[0]), 64'h11_1111_1112);
    check("rt_nr_mid", 64'(gain_o[1]), 64'h11_1111_1114);
    check("rt_done", 64'(done_cnt[0] - c0), 64'd1);
    ticks(20);
    check("rt_nr_end", 64'(gain_o[1]), 64'h11_1111_1119);
    check("rt_nr_done", 64'(done_cnt[1] - c1), 64'd1);

    // Accept on a step-eligible tick: no step, counter restarts.
    do_reset();
    load(40'h11_1111_1115);
    ticks(3);
    @(negedge clk);
    sample_tick = 1'b1;
    load_valid  = 1'b1;
    gain_target = 40'h11_1111_1117;
    @(negedge clk);
    sample_tick = 1'b0;
    load_valid  = 1'b0;
    check("coin_hold", 64'(gain_o[0]), 64'h11_1111_1111);
    check("coin_nr_step", 64'(gain_o[1]), 64'h11_1111_1112);
    ticks(3);
    check("coin_t3", 64'(gain_o[0]), 64'h11_1111_1111);
    ticks(1);
    check("coin_t4", 64'(gain_o[0]), 64'h11_1111_1112);
    idle(100);
    check("freeze", 64'(gain_o[0]), 64'h11_1111_1112);
    check("freeze_nr", 64'(gain_o[1]), 64'h11_1111_1113);

    // Reset mid-ramp: back to unity, no done; a fresh load ramps normally.
    do_reset();
    c0 = done_cnt[0];
    load(40'h11_1111_1115);
    ticks(6);
    check("ab_t6", 64'(gain_o[0]), 64'h11_1111_1112);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check("ab_gain", 64'(gain_o[0]), 64'h11_1111_1111);
    check("ab_settled", 64'(settled_o[0]), 64'd1);
    check("ab_done", 64'(done_cnt[0] - c0), 64'd0);
    load(40'h11_1111_1113);
    ticks(8);
    check("ab_reload", 64'(gain_o[0]), 64'h11_1111_1113);
    check("ab_reload_done", 64'(done_cnt[0] - c0), 64'd1);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
